// File: rtl/cmd_queue_pkg.sv
// Shared types and constants for the issuer command queue.
package cmd_queue_pkg;

  localparam int CMDQ_DEPTH = 16;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  tag;
    logic [19:0] arg;
  } cmd_t;

endpackage

// File: rtl/cmdq_mem.sv
// Command storage: register array, one synchronous write port, one combinational read port.
module cmdq_mem
  import cmd_queue_pkg::*;
#(
  parameter int DEPTH = CMDQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_ptr,
  input  cmd_t             wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output cmd_t             rd_data
);

  cmd_t mem [DEPTH];

  // Storage is deliberately not reset; the head is ignored while the queue is empty.
  always_ff @(posedge i_clk) begin
    if (we) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/cmd_queue.sv
// Show-ahead command FIFO between host pushes and the issuer's read strobe.
// Optional high-watermark and push counters are built when CMDQ_STATS_EN is defined.
module cmd_queue
  import cmd_queue_pkg::*;
#(
  parameter  int DEPTH = CMDQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_wr_en,
  input  cmd_t             i_wr_cmd,
  output logic             o_full,
  input  logic             i_rd,
  output cmd_t             o_cmd,
  output logic             o_empty,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic             o_underflow
`ifdef CMDQ_STATS_EN
  ,
  output logic [CNT_W-1:0] o_max_count,
  output logic [31:0]      o_push_total
`endif
);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, cnt_nxt;
  logic             push_ok, pop_ok;

  // Full/empty come from the registered count only, so accept logic has no input-to-output path.
  assign o_full  = (count == CNT_W'(DEPTH));
  assign o_empty = (count == '0);
  assign o_count = count;

  assign push_ok = i_wr_en && !o_full && !i_flush;
  assign pop_ok  = i_rd && !o_empty && !i_flush;

  always_comb begin
    cnt_nxt = count;
    if (i_flush)                cnt_nxt = '0;
    else if (push_ok && !pop_ok) cnt_nxt = count + CNT_W'(1);
    else if (pop_ok && !push_ok) cnt_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= cnt_nxt;
      if (i_wr_en && o_full) o_overflow  <= 1'b1;
      if (i_rd && o_empty)   o_underflow <= 1'b1;
    end
  end

  cmdq_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .i_clk   (i_clk),
    .we      (push_ok),
    .wr_ptr  (wr_ptr),
    .wr_data (i_wr_cmd),
    .rd_ptr  (rd_ptr),
    .rd_data (o_cmd)
  );

`ifdef CMDQ_STATS_EN
  // Statistics survive flush; only reset clears them.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_max_count  <= '0;
      o_push_total <= '0;
    end else begin
      if (cnt_nxt > o_max_count) o_max_count <= cnt_nxt;
      if (push_ok && o_push_total != 32'hFFFF_FFFF) o_push_total <= o_push_total + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmd_queue.sv
// Randomized self-checking bench for cmd_queue against a queue-based reference model.
module tb_cmd_queue;
  import cmd_queue_pkg::*;

  localparam int DEPTH = CMDQ_DEPTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             i_clk = 1'b0;
  logic             i_rstn;
  logic             i_wr_en;
  cmd_t             i_wr_cmd;
  logic             o_full;
  logic             i_rd;
  cmd_t             o_cmd;
  logic             o_empty;
  logic             i_flush;
  logic [CNT_W-1:0] o_count;
  logic             o_overflow;
  logic             o_underflow;
`ifdef CMDQ_STATS_EN
  logic [CNT_W-1:0] o_max_count;
  logic [31:0]      o_push_total;
`endif

  always #5 i_clk = ~i_clk;

  cmd_queue #(.DEPTH(DEPTH)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_wr_en     (i_wr_en),
    .i_wr_cmd    (i_wr_cmd),
    .o_full      (o_full),
    .i_rd        (i_rd),
    .o_cmd       (o_cmd),
    .o_empty     (o_empty),
    .i_flush     (i_flush),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
`ifdef CMDQ_STATS_EN
    ,
    .o_max_count (o_max_count),
    .o_push_total(o_push_total)
`endif
  );

  // Reference model state
  logic [31:0] mq[$];
  bit          m_ovf, m_unf;
  int          m_max, m_tot;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_unf = 0; m_max = 0; m_tot = 0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".count"}, 32'(o_count), 32'(mq.size()));
    chk({ph, ".empty"}, 32'(o_empty), 32'(mq.size() == 0));
    chk({ph, ".full"},  32'(o_full),  32'(mq.size() == DEPTH));
    chk({ph, ".ovf"},   32'(o_overflow),  32'(m_ovf));
    chk({ph, ".unf"},   32'(o_underflow), 32'(m_unf));
    if (mq.size() != 0) chk({ph, ".head"}, o_cmd, mq[0]);
`ifdef CMDQ_STATS_EN
    chk({ph, ".max"},   32'(o_max_count), 32'(m_max));
    chk({ph, ".tot"},   o_push_total, 32'(m_tot));
`endif
  endtask

  // Drive one cycle (inputs applied after a falling edge), model the edge, check at next falling edge.
  task automatic cycle(input string ph, input bit wr, input logic [31:0] d, input bit rd, input bit fl);
    bit pa, pp;
    i_wr_en = wr; i_wr_cmd = cmd_t'(d); i_rd = rd; i_flush = fl;
    @(posedge i_clk);
    if (fl) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      pa = wr && (mq.size() != DEPTH);
      pp = rd && (mq.size() != 0);
      if (wr && !pa) m_ovf = 1;
      if (rd && !pp) m_unf = 1;
      if (pp) void'(mq.pop_front());
      if (pa) begin mq.push_back(d); m_tot++; end
    end
    if (mq.size() > m_max) m_max = mq.size();
    @(negedge i_clk);
    i_wr_en = 0; i_rd = 0; i_flush = 0;
    check_all(ph);
  endtask

  initial begin
    int writes;
    bit w, r;
    i_rstn = 0; i_wr_en = 0; i_rd = 0; i_flush = 0; i_wr_cmd = '0;
    model_reset();
    repeat (2) @(negedge i_clk);
    check_all("rst");
    i_rstn = 1;

    // A,B,C then three pops
    cycle("pushA", 1, 32'hA000_000A, 0, 0);
    cycle("pushB", 1, 32'hB000_000B, 0, 0);
    cycle("pushC", 1, 32'hC000_000C, 0, 0);
    for (int i = 0; i < 3; i++) cycle("pop3", 0, 0, 1, 0);

    // Fill then push+pop while full
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1, $urandom, 0, 0);
    cycle("fullpp", 1, 32'hDEAD_BEEF, 1, 0);
    while (mq.size() != 0) cycle("drain", 0, 0, 1, 0);
    cycle("flush1", 0, 0, 0, 1);

    // Empty with push+pop
    cycle("emptypp", 1, 32'h1234_5678, 1, 0);
    cycle("flush2", 0, 0, 0, 1);

    // 40 writes with occupancy <= 5 across pointer wrap
    writes = 0;
    for (int i = 0; i < 2000 && writes < 40; i++) begin
      w = (mq.size() < 5) && ($urandom_range(0, 1) == 1);
      r = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
      if (w) writes++;
      cycle("wrap", w, $urandom, r, 0);
    end
    while (mq.size() != 0) cycle("wrapdrain", 0, 0, 1, 0);

    // Asynchronous reset between edges
    cycle("prerst", 1, $urandom, 0, 0);
    #2 i_rstn = 0;
    #1 model_reset();
    check_all("asyncrst");
    @(negedge i_clk);
    i_rstn = 1;

    // Load 7, flush with concurrent push
    for (int i = 0; i < 7; i++) cycle("load7", 1, $urandom, 0, 0);
    cycle("flushwr", 1, 32'hFFFF_0000, 0, 1);

    // Free-running random traffic
    for (int i = 0; i < 400; i++)
      cycle("rand", $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
            $urandom_range(0, 63) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/cmd_queue.md
Name: cmd_queue

Overview:
- Command FIFO feeding the issuer's command-queue port: host/testbench side pushes cmd_t words; issuer side pops them with its read strobe.
- Responder end of the issuer's queue interface; drives the issuer's command and queue-empty inputs and consumes its read strobe.
- Show-ahead (first-word-fall-through), register-array storage, single clock domain.

Parameters:
- DEPTH, 16, number of cmd_t entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden).
- CNT_W, $clog2(DEPTH+1), occupancy width (derived).

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  reset, asynchronous, active-low.
- i_wr_en  input  1  push request from host side.
- i_wr_cmd  input  $bits(cmd_t)  command to push.
- o_full  output  1  queue holds DEPTH entries.
- i_rd  input  1  pop strobe; connects to the issuer's read-queue output.
- o_cmd  output  $bits(cmd_t)  head entry (cmd_t); connects to the issuer's command input.
- o_empty  output  1  no entries; connects to the issuer's queue-empty input.
- i_flush  input  1  synchronous discard of all entries.
- o_count  output  CNT_W  current occupancy.
- o_overflow  output  1  sticky: push attempted while full.
- o_underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, i_rstn low): wr_ptr=0, rd_ptr=0, count=0, o_empty=1, o_full=0, o_overflow=0, o_underflow=0. Storage is not reset; o_cmd is don't-care while o_empty=1.
- o_cmd = mem[rd_ptr], combinational from storage. It is valid whenever o_empty=0. The issuer samples it in the same cycle that it asserts i_rd.
- Push: i_wr_en && !o_full -> mem[wr_ptr] <= i_wr_cmd, wr_ptr+1 at the clock edge. A write into an empty queue is visible on o_cmd, with o_empty=0, the next cycle (1-cycle write-to-read latency).
- Pop: i_rd && !o_empty -> rd_ptr+1 at the clock edge. The next head appears the following cycle.
- Pointers wrap modulo DEPTH by natural PTR_W overflow.
- count: +1 on accepted push only, -1 on accepted pop only, unchanged when both are accepted.
- o_full = (count==DEPTH). o_empty = (count==0). Both are derived from the registered count, so there is no combinational path from i_wr_en or i_rd.
- Full and push+pop in the same cycle: the pop is accepted. The push is rejected because o_full is evaluated before the pop, so o_overflow is set.
- Empty and push+pop in the same cycle: the push is accepted. The pop is rejected and o_underflow is set. No bypass.
- Rejected operations never move pointers or alter storage.
- i_flush has priority over push and pop in the same cycle. Effects: pointers and count go to 0; o_overflow and o_underflow clear; the concurrent push is dropped and does not set o_overflow.
- Sticky flags are cleared only by reset or i_flush.
- Reset asserted mid-operation: state returns to reset values immediately, whatever push or pop is in flight.

Optional Feature:
- Macro CMDQ_STATS_EN. When defined, it adds two outputs:
  - o_max_count (CNT_W): high-watermark of count; updated with the post-edge count value.
  - o_push_total (32): accepted pushes; saturates at 32'hFFFF_FFFF.
- Both reset to 0; neither is cleared by i_flush.
- When not defined: the ports and logic are absent; base behaviour is identical.

Decomposition:
- Shared package: cmd_t (existing), constant CMDQ_DEPTH (default 16) for top-level instantiation.
- Sub-module cmdq_mem: DEPTH x $bits(cmd_t) register array; one synchronous write port; one combinational read port addressed by rd_ptr.
- Pointer, count and flag logic stay in cmd_queue.

Test Plan:
- Reset, then push A,B,C on consecutive cycles with i_rd=0 -> o_empty falls 1 cycle after the A push; o_cmd=A; o_count=3.
- Continue from the previous state: pop 3 consecutive cycles -> o_cmd steps A, B, C; o_empty=1 the cycle after the third pop; o_underflow stays 0.
- Fill 16 entries, then push+pop in the same cycle -> o_count 16 then 15; o_overflow=1; the popped entry is the first written; the rejected word never appears.
- Empty queue, push X and pop the same cycle -> o_underflow=1; next cycle o_cmd=X, o_count=1.
- Write 40 entries interleaved with pops, keeping occupancy <= 5 -> FIFO order is preserved across pointer wrap, with no flag set.
- Load 7 entries, assert i_flush with i_wr_en=1 -> next cycle o_count=0, o_empty=1, flags 0; with CMDQ_STATS_EN, o_max_count=7 and o_push_total=7.
